pkt_buffer_mem: RTL and testbench
=================================

Name: pkt_buffer_mem

Overview:
- Byte-addressed packet buffer and the responder for the executor's memory port (ce/we/addr/width/data).
- A byte-stream loader fills the buffer; the executor then reads and writes packet bytes in place with 1–4 byte accesses; on release the buffer streams the packet out.
- Sits between the ingress/parser path and egress; pkt_ready_o drives the executor's start.

Parameters:
DEPTH, 2048, buffer size in bytes (power of two).
ADDR_W, 32, address width (matches the codebase address bus).
DATA_W, 32, memory data width (matches the codebase data bus; fixed at 32).

Ports:
clk  input  1  clock
rst  input  1  asynchronous active-high reset
ld_valid_i  input  1  loader byte valid
ld_data_i  input  8  loader byte
ld_last_i  input  1  final byte of packet
ld_ready_o  output  1  buffer accepts loader byte
pkt_ready_o  output  1  packet held, executor access enabled
pkt_len_o  output  ADDR_W  stored packet length in bytes
overflow_o  output  1  loader sent more than DEPTH bytes
mem_ce_i  input  1  executor access enable
mem_we_i  input  1  1 = write, 0 = read
mem_addr_i  input  ADDR_W  byte address
mem_width_i  input  4  access width in bytes, 1..4
mem_data_i  input  DATA_W  write data, right-aligned
mem_data_o  output  DATA_W  read data, right-aligned
release_i  input  1  executor done; start egress
out_valid_o  output  1  egress byte valid
out_data_o  output  8  egress byte
out_last_o  output  1  final egress byte

Behaviour:
- Reset (async, rst=1):
  - State is EMPTY.
  - All outputs are 0 except ld_ready_o=1.
  - Write pointer, length, drain pointer and overflow are cleared. Buffer contents are not cleared.
  - Reset mid-operation abandons the packet.
- States: EMPTY, LOAD, HOLD, DRAIN.
- EMPTY/LOAD: ld_ready_o=1.
  - A byte is taken when ld_valid_i&ld_ready_o. It is written at wptr, then wptr+1.
  - The first accepted byte moves EMPTY→LOAD.
  - ld_last_i on an accepted byte:
    - pkt_len_o <= min(wptr+1, DEPTH).
    - ld_ready_o <= 0 and pkt_ready_o <= 1 on the next cycle; state → HOLD.
  - If wptr==DEPTH, the byte is dropped, overflow_o<=1 (sticky until the next EMPTY), and wptr does not advance.
- HOLD: pkt_ready_o=1 (level).
  - Executor accesses act only in HOLD. In other states, writes are ignored and a read returns 0.
  - Byte address index = mem_addr_i mod DEPTH; each byte wraps independently.
  - Big-endian: byte at addr is the most significant of the width bytes.
  - Read (ce=1, we=0) sampled at edge N:
    - mem_data_o is valid after edge N, i.e. one-cycle latency.
    - mem_data_o = {zero pad, B[a], B[a+1], …, B[a+w-1]}.
    - It holds until the next read.
  - Write (ce=1, we=1) sampled at edge N:
    - B[a+i] <= mem_data_i[8(w-1-i)+7 : 8(w-1-i)] for i=0..w-1.
    - Visible to a read sampled at edge N+1.
  - Width 0 or >4: write ignored, read returns 0.
  - Back-to-back accesses every cycle are supported, with no wait states.
  - release_i in HOLD:
    - pkt_ready_o<=0, drain pointer <= 0, state → DRAIN.
    - An access in the same cycle as release_i is still performed.
- DRAIN:
  - out_valid_o=1 and out_data_o=B[dptr]; out_last_o=(dptr==pkt_len_o-1).
  - Egress is never stalled: one byte per cycle, next cycle.
  - After the last byte: out_valid_o<=0, ld_ready_o<=1, overflow_o<=0, state → EMPTY.
- release_i outside HOLD and ld_valid_i outside EMPTY/LOAD are ignored.

Decomposition:
- Shared def header:
  - PB_STATE_EMPTY/LOAD/HOLD/DRAIN and a PB_STATE_BUS width.
  - Reuse ZERO_WORD/ZERO_ADDR/TRUE/FALSE.
- One sub-module, pkt_byte_ram:
  - Byte-lane RAM with 4 write lanes and 4 read lanes at wrapped consecutive addresses.
  - Width-masked, registered read.
  - The top level holds the FSM, pointers and access multiplexing: loader/drain lane 0 vs executor lanes.

Test Plan:
- Load 6 bytes 0x45,0x00,0x00,0x54,0xAB,0xCD with last on 0xCD → pkt_ready_o=1 one cycle later, pkt_len_o=6, overflow_o=0.
- HOLD read addr=0 width=4 → next cycle mem_data_o=0x45000054. Then read addr=4 width=2 → 0x0000ABCD.
- Write addr=2 width=2 data=0x00001234, next-cycle read addr=0 width=4 → 0x45001234. Write width=0 → contents unchanged.
- Read addr=DEPTH-1 width=2 → {B[DEPTH-1],B[0]}. Access in EMPTY → write ignored, read returns 0.
- Load DEPTH+3 bytes → overflow_o=1, pkt_len_o=DEPTH. Then release → DEPTH egress bytes, overflow cleared at EMPTY.
- release_i after edits → out_data_o 0x45,0x00,0x12,0x34,0xAB,0xCD on consecutive cycles, out_last_o on the 6th. Assert rst mid-drain → out_valid_o=0 immediately, ld_ready_o=1.

Source files
------------

// File: rtl/pkt_buffer_mem_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_buffer_mem_pkg : shared state encoding and constants for the packet buffer
// Revision 1.0
// ----------------------------------------------------------------------------
package pkt_buffer_mem_pkg;

   localparam int PB_STATE_BUS = 2;

   typedef enum logic [PB_STATE_BUS-1:0] {
      PB_STATE_EMPTY = 2'd0,
      PB_STATE_LOAD  = 2'd1,
      PB_STATE_HOLD  = 2'd2,
      PB_STATE_DRAIN = 2'd3
   } pb_state_t;

   localparam logic [31:0] ZERO_WORD = 32'h0000_0000;
   localparam logic [31:0] ZERO_ADDR = 32'h0000_0000;
   localparam logic        TRUE      = 1'b1;
   localparam logic        FALSE     = 1'b0;

   // Legal executor access widths are 1..4 bytes.
   function automatic logic width_ok(input logic [3:0] w);
      return (w != 4'd0) && (w <= 4'd4);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pkt_buffer_mem_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_byte_ram : byte RAM with 4 write/read lanes at wrapped consecutive addresses
// Revision 1.0
// ----------------------------------------------------------------------------
module pkt_byte_ram
   import pkt_buffer_mem_pkg::*;
#(
   parameter int DEPTH = 2048,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [3:0]    wr_width,
   input  logic [31:0]   wr_data,
   input  logic          rd_en,
   input  logic [AW-1:0] rd_addr,
   input  logic [3:0]    rd_width,
   output logic [31:0]   rd_data,
   input  logic [AW-1:0] peek_addr,
   output logic [7:0]    peek_data
);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] w_wr_lane_addr [4];
   logic [7:0]    w_wr_lane_data [4];
   logic          w_wr_lane_en   [4];
   logic [AW-1:0] w_rd_lane_addr [4];
   logic [31:0]   w_rd_word;

   // Lane i carries the byte at base+i; base byte is the most significant of the access.
   generate
      for (genvar i = 0; i < 4; i++) begin : g_lane
         assign w_wr_lane_addr[i] = wr_addr + AW'(i);
         assign w_rd_lane_addr[i] = rd_addr + AW'(i);
         assign w_wr_lane_en[i]   = wr_en && width_ok(wr_width) && (wr_width > 4'(i));
         assign w_wr_lane_data[i] = 8'(wr_data >> {wr_width - 4'd1 - 4'(i), 3'b000});
      end
   endgenerate

   always_ff @(posedge clk) begin
      for (int i = 0; i < 4; i++) begin
         if (w_wr_lane_en[i]) begin
            r_mem[w_wr_lane_addr[i]] <= w_wr_lane_data[i];
         end
      end
   end

   always_comb begin
      w_rd_word = ZERO_WORD;
      if (width_ok(rd_width)) begin
         for (int i = 0; i < 4; i++) begin
            if (4'(i) < rd_width) begin
               w_rd_word = w_rd_word |
                  (32'(r_mem[w_rd_lane_addr[i]]) << {rd_width - 4'd1 - 4'(i), 3'b000});
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rd_data <= ZERO_WORD;
      end else if (rd_en) begin
         rd_data <= w_rd_word;
      end
   end

   assign peek_data = r_mem[peek_addr];

endmodule
`default_nettype wire

// File: rtl/pkt_buffer_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pkt_buffer_mem : packet buffer with loader ingress, executor memory port, egress drain
// Revision 1.0
// ----------------------------------------------------------------------------
module pkt_buffer_mem
   import pkt_buffer_mem_pkg::*;
#(
   parameter int DEPTH  = 2048,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ld_valid_i,
   input  logic [7:0]        ld_data_i,
   input  logic              ld_last_i,
   output logic              ld_ready_o,
   output logic              pkt_ready_o,
   output logic [ADDR_W-1:0] pkt_len_o,
   output logic              overflow_o,
   input  logic              mem_ce_i,
   input  logic              mem_we_i,
   input  logic [ADDR_W-1:0] mem_addr_i,
   input  logic [3:0]        mem_width_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic [DATA_W-1:0] mem_data_o,
   input  logic              release_i,
   output logic              out_valid_o,
   output logic [7:0]        out_data_o,
   output logic              out_last_o
);

   localparam int AW = $clog2(DEPTH);

   pb_state_t         r_state;
   pb_state_t         w_state_nxt;
   logic [AW:0]       r_wptr;
   logic [ADDR_W-1:0] r_len;
   logic [ADDR_W-1:0] r_dptr;
   logic              r_overflow;

   logic              w_ld_accept;
   logic              w_full;
   logic              w_hold;
   logic              w_drain_last;
   logic              w_ld_path;
   logic              w_wr_en;
   logic [AW-1:0]     w_wr_addr;
   logic [3:0]        w_wr_width;
   logic [31:0]       w_wr_data;
   logic [7:0]        w_peek;
   logic              w_unused_bits;

   assign w_ld_accept  = ld_valid_i && ld_ready_o;
   assign w_full       = (r_wptr == (AW+1)'(DEPTH));
   assign w_hold       = (r_state == PB_STATE_HOLD);
   assign w_drain_last = (r_dptr == (r_len - ADDR_W'(1)));
   assign w_unused_bits = ^{mem_addr_i[ADDR_W-1:AW], r_dptr[ADDR_W-1:AW]};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= PB_STATE_EMPTY;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      ld_ready_o  = FALSE;
      pkt_ready_o = FALSE;
      out_valid_o = FALSE;
      out_last_o  = FALSE;
      out_data_o  = 8'h00;
      case (r_state)
         PB_STATE_EMPTY, PB_STATE_LOAD: begin
            ld_ready_o = TRUE;
            if (w_ld_accept) begin
               w_state_nxt = ld_last_i ? PB_STATE_HOLD : PB_STATE_LOAD;
            end
         end
         PB_STATE_HOLD: begin
            pkt_ready_o = TRUE;
            if (release_i) begin
               w_state_nxt = PB_STATE_DRAIN;
            end
         end
         PB_STATE_DRAIN: begin
            out_valid_o = TRUE;
            out_data_o  = w_peek;
            out_last_o  = w_drain_last;
            if (w_drain_last) begin
               w_state_nxt = PB_STATE_EMPTY;
            end
         end
         default: w_state_nxt = PB_STATE_EMPTY;
      endcase
   end

   // Bytes past DEPTH are dropped but ld_last still closes the packet.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr     <= '0;
         r_len      <= ADDR_W'(ZERO_ADDR);
         r_dptr     <= ADDR_W'(ZERO_ADDR);
         r_overflow <= FALSE;
      end else begin
         case (r_state)
            PB_STATE_EMPTY, PB_STATE_LOAD: begin
               if (w_ld_accept) begin
                  if (w_full) begin
                     r_overflow <= TRUE;
                  end else begin
                     r_wptr <= r_wptr + (AW+1)'(1);
                  end
                  if (ld_last_i) begin
                     r_len <= w_full ? ADDR_W'(DEPTH) : (ADDR_W'(r_wptr) + ADDR_W'(1));
                  end
               end
            end
            PB_STATE_HOLD: begin
               if (release_i) begin
                  r_dptr <= ADDR_W'(ZERO_ADDR);
               end
            end
            PB_STATE_DRAIN: begin
               r_dptr <= r_dptr + ADDR_W'(1);
               if (w_drain_last) begin
                  r_wptr     <= '0;
                  r_overflow <= FALSE;
               end
            end
            default: ;
         endcase
      end
   end

   assign pkt_len_o  = r_len;
   assign overflow_o = r_overflow;

   // Loader owns lane 0 while filling; the executor owns all lanes in HOLD.
   assign w_ld_path  = (r_state == PB_STATE_EMPTY) || (r_state == PB_STATE_LOAD);
   assign w_wr_en    = w_ld_path ? (w_ld_accept && !w_full) : (w_hold && mem_ce_i && mem_we_i);
   assign w_wr_addr  = w_ld_path ? r_wptr[AW-1:0] : mem_addr_i[AW-1:0];
   assign w_wr_width = w_ld_path ? 4'd1 : mem_width_i;
   assign w_wr_data  = w_ld_path ? {24'h000000, ld_data_i} : 32'(mem_data_i);

   pkt_byte_ram #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_ram (
      .clk       (clk),
      .rst       (rst),
      .wr_en     (w_wr_en),
      .wr_addr   (w_wr_addr),
      .wr_width  (w_wr_width),
      .wr_data   (w_wr_data),
      .rd_en     (mem_ce_i && !mem_we_i),
      .rd_addr   (mem_addr_i[AW-1:0]),
      .rd_width  (w_hold ? mem_width_i : 4'd0),
      .rd_data   (mem_data_o),
      .peek_addr (r_dptr[AW-1:0]),
      .peek_data (w_peek)
   );

endmodule
`default_nettype wire

// File: tb/tb_pkt_buffer_mem.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pkt_buffer_mem : directed self-checking bench for pkt_buffer_mem
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_pkt_buffer_mem;

   localparam int DEPTH  = 64;
   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   logic              clk;
   logic              rst;
   logic              ld_valid_i;
   logic [7:0]        ld_data_i;
   logic              ld_last_i;
   logic              ld_ready_o;
   logic              pkt_ready_o;
   logic [ADDR_W-1:0] pkt_len_o;
   logic              overflow_o;
   logic              mem_ce_i;
   logic              mem_we_i;
   logic [ADDR_W-1:0] mem_addr_i;
   logic [3:0]        mem_width_i;
   logic [DATA_W-1:0] mem_data_i;
   logic [DATA_W-1:0] mem_data_o;
   logic              release_i;
   logic              out_valid_o;
   logic [7:0]        out_data_o;
   logic              out_last_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [7:0] pkt_buf [0:7];

   pkt_buffer_mem #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .ld_valid_i  (ld_valid_i),
      .ld_data_i   (ld_data_i),
      .ld_last_i   (ld_last_i),
      .ld_ready_o  (ld_ready_o),
      .pkt_ready_o (pkt_ready_o),
      .pkt_len_o   (pkt_len_o),
      .overflow_o  (overflow_o),
      .mem_ce_i    (mem_ce_i),
      .mem_we_i    (mem_we_i),
      .mem_addr_i  (mem_addr_i),
      .mem_width_i (mem_width_i),
      .mem_data_i  (mem_data_i),
      .mem_data_o  (mem_data_o),
      .release_i   (release_i),
      .out_valid_o (out_valid_o),
      .out_data_o  (out_data_o),
      .out_last_o  (out_last_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic set_access(input logic ce, input logic we, input logic [31:0] addr,
                             input logic [3:0] w, input logic [31:0] d);
      mem_ce_i    = ce;
      mem_we_i    = we;
      mem_addr_i  = addr;
      mem_width_i = w;
      mem_data_i  = d;
   endtask

   // mode 0: bytes from pkt_buf; mode 1: byte value = index
   task automatic load_seq(input int n, input int mode);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         ld_valid_i = 1'b1;
         ld_data_i  = (mode == 0) ? pkt_buf[i] : 8'(i);
         ld_last_i  = (i == n - 1);
      end
      @(negedge clk);
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      ld_valid_i = 1'b0; ld_data_i = 8'h00; ld_last_i = 1'b0; release_i = 1'b0;
      set_access(1'b0, 1'b0, 32'h0, 4'd0, 32'h0);
      repeat (2) @(negedge clk);
      n_checks++;
      if ({ld_ready_o, pkt_ready_o, overflow_o, out_valid_o, out_last_o} !== 5'b10000) begin
         n_fail++;
         $display("FAIL reset_flags: got %b expected 10000",
                  {ld_ready_o, pkt_ready_o, overflow_o, out_valid_o, out_last_o});
      end
      n_checks++;
      if ({pkt_len_o, mem_data_o, out_data_o} !== 72'h0) begin
         n_fail++;
         $display("FAIL reset_data: got %h expected 0", {pkt_len_o, mem_data_o, out_data_o});
      end
      rst = 1'b0;
   endtask

   task automatic test_load;
      pkt_buf[0] = 8'h45; pkt_buf[1] = 8'h00; pkt_buf[2] = 8'h00;
      pkt_buf[3] = 8'h54; pkt_buf[4] = 8'hAB; pkt_buf[5] = 8'hCD;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (i == 5) begin
            n_checks++;
            if (pkt_ready_o !== 1'b0) begin
               n_fail++;
               $display("FAIL load_pkt_ready_early: got %b expected 0", pkt_ready_o);
            end
         end
         ld_valid_i = 1'b1;
         ld_data_i  = pkt_buf[i];
         ld_last_i  = (i == 5);
      end
      @(negedge clk);
      ld_valid_i = 1'b0;
      ld_last_i  = 1'b0;
      n_checks++;
      if ({pkt_ready_o, ld_ready_o, overflow_o} !== 3'b100) begin
         n_fail++;
         $display("FAIL load_flags: got %b expected 100", {pkt_ready_o, ld_ready_o, overflow_o});
      end
      n_checks++;
      if (pkt_len_o !== 32'd6) begin
         n_fail++;
         $display("FAIL load_len: got %0d expected 6", pkt_len_o);
      end
   endtask

   task automatic test_read;
      @(negedge clk); set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h45000054) begin
         n_fail++;
         $display("FAIL read_a0_w4: got %h expected 45000054", mem_data_o);
      end
      set_access(1'b1, 1'b0, 32'd4, 4'd2, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h0000ABCD) begin
         n_fail++;
         $display("FAIL read_a4_w2: got %h expected 0000abcd", mem_data_o);
      end
      set_access(1'b1, 1'b0, 32'd3, 4'd3, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h0054ABCD) begin
         n_fail++;
         $display("FAIL read_a3_w3: got %h expected 0054abcd", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h0054ABCD) begin
         n_fail++;
         $display("FAIL read_hold: got %h expected 0054abcd", mem_data_o);
      end
      set_access(1'b1, 1'b0, 32'h0000_1000, 4'd1, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h00000045) begin
         n_fail++;
         $display("FAIL read_high_addr: got %h expected 00000045", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
   endtask

   task automatic test_write;
      @(negedge clk); set_access(1'b1, 1'b1, 32'd2, 4'd2, 32'h0000_1234);
      @(negedge clk); set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h45001234) begin
         n_fail++;
         $display("FAIL write_w2: got %h expected 45001234", mem_data_o);
      end
      set_access(1'b1, 1'b1, 32'd0, 4'd0, 32'hFFFF_FFFF);
      @(negedge clk); set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h45001234) begin
         n_fail++;
         $display("FAIL write_w0_ignored: got %h expected 45001234", mem_data_o);
      end
      set_access(1'b1, 1'b0, 32'd0, 4'd5, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h0) begin
         n_fail++;
         $display("FAIL read_w5_zero: got %h expected 00000000", mem_data_o);
      end
      set_access(1'b1, 1'b1, 32'(DEPTH - 1), 4'd1, 32'h0000_0077);
      @(negedge clk); set_access(1'b1, 1'b0, 32'(DEPTH - 1), 4'd2, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h00007745) begin
         n_fail++;
         $display("FAIL read_wrap: got %h expected 00007745", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
   endtask

   task automatic test_release;
      logic [7:0] exp_b [0:5];
      exp_b[0] = 8'h45; exp_b[1] = 8'h00; exp_b[2] = 8'h12;
      exp_b[3] = 8'h34; exp_b[4] = 8'hAB; exp_b[5] = 8'hCD;
      @(negedge clk);
      release_i = 1'b1;
      set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      release_i = 1'b0;
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
      n_checks++;
      if ({pkt_ready_o, mem_data_o} !== {1'b0, 32'h45001234}) begin
         n_fail++;
         $display("FAIL release_same_cycle: got %b/%h expected 0/45001234", pkt_ready_o, mem_data_o);
      end
      for (int k = 0; k < 6; k++) begin
         if (k > 0) @(negedge clk);
         n_checks++;
         if ({out_valid_o, out_last_o, out_data_o} !== {1'b1, (k == 5), exp_b[k]}) begin
            n_fail++;
            $display("FAIL drain_byte%0d: got v%b l%b %h expected v1 l%b %h",
                     k, out_valid_o, out_last_o, out_data_o, (k == 5), exp_b[k]);
         end
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid_o, ld_ready_o, pkt_ready_o} !== 3'b010) begin
         n_fail++;
         $display("FAIL drain_end: got %b expected 010", {out_valid_o, ld_ready_o, pkt_ready_o});
      end
   endtask

   task automatic test_empty_access;
      @(negedge clk); set_access(1'b1, 1'b1, 32'd2, 4'd2, 32'h0000_BEEF);
      @(negedge clk); set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h0) begin
         n_fail++;
         $display("FAIL empty_read_zero: got %h expected 00000000", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
      pkt_buf[0] = 8'h11; pkt_buf[1] = 8'h22;
      load_seq(2, 0);
      set_access(1'b1, 1'b0, 32'd0, 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h11221234) begin
         n_fail++;
         $display("FAIL empty_write_ignored: got %h expected 11221234", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
   endtask

   task automatic test_reset_mid_drain;
      @(negedge clk); release_i = 1'b1;
      @(negedge clk); release_i = 1'b0;
      n_checks++;
      if ({out_valid_o, out_data_o} !== {1'b1, 8'h11}) begin
         n_fail++;
         $display("FAIL drain2_first: got v%b %h expected v1 11", out_valid_o, out_data_o);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid_o, ld_ready_o, pkt_ready_o} !== 3'b010) begin
         n_fail++;
         $display("FAIL reset_mid_drain: got %b expected 010", {out_valid_o, ld_ready_o, pkt_ready_o});
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_overflow;
      load_seq(DEPTH + 3, 1);
      n_checks++;
      if ({overflow_o, pkt_ready_o, pkt_len_o} !== {1'b1, 1'b1, 32'(DEPTH)}) begin
         n_fail++;
         $display("FAIL overflow_flags: got ov%b rdy%b len%0d expected ov1 rdy1 len%0d",
                  overflow_o, pkt_ready_o, pkt_len_o, DEPTH);
      end
      set_access(1'b1, 1'b0, 32'(DEPTH - 4), 4'd4, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h3C3D3E3F) begin
         n_fail++;
         $display("FAIL overflow_tail: got %h expected 3c3d3e3f", mem_data_o);
      end
      set_access(1'b1, 1'b0, 32'd0, 4'd2, 32'h0);
      @(negedge clk);
      n_checks++;
      if (mem_data_o !== 32'h00000001) begin
         n_fail++;
         $display("FAIL overflow_no_wrap: got %h expected 00000001", mem_data_o);
      end
      set_access(1'b0, 1'b0, 32'd0, 4'd0, 32'h0);
      @(negedge clk); release_i = 1'b1;
      @(negedge clk); release_i = 1'b0;
      for (int k = 0; k < DEPTH; k++) begin
         if (k > 0) @(negedge clk);
         n_checks++;
         if ({out_valid_o, out_last_o, overflow_o, out_data_o} !==
             {1'b1, (k == DEPTH - 1), 1'b1, 8'(k)}) begin
            n_fail++;
            $display("FAIL ovf_drain%0d: got v%b l%b ov%b %h expected v1 l%b ov1 %h",
                     k, out_valid_o, out_last_o, overflow_o, out_data_o, (k == DEPTH - 1), 8'(k));
         end
      end
      @(negedge clk);
      n_checks++;
      if ({out_valid_o, ld_ready_o, overflow_o} !== 3'b010) begin
         n_fail++;
         $display("FAIL overflow_cleared: got %b expected 010", {out_valid_o, ld_ready_o, overflow_o});
      end
   endtask

   initial begin
      test_reset();
      test_load();
      test_read();
      test_write();
      test_release();
      test_empty_access();
      test_reset_mid_drain();
      test_overflow();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
